toy_stq_ctrl: RTL and testbench

Store-queue controller between toy_stu and the data-memory bus. Buffers address-generated stores (stu_pkg) in a circular queue and marks them committed in program order on ROB commit. Drains committed stores to memory one at a time with a request/ack handshake. Discards speculative (uncommitted) entries on pipeline flush.

---
 rtl/toy_stq_ctrl_pkg.sv | 43 ++++
 rtl/toy_stq_ctrl_ptr.sv | 34 +++
 rtl/toy_stq_ctrl.sv | 141 ++++++++++++++
 tb/tb_toy_stq_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/toy_stq_ctrl_pkg.sv
// Shared types for the store-queue controller: STU store payload, queue entry
// layout and drain FSM states.
package toy_stq_ctrl_pkg;

  localparam int ADDR_WIDTH    = 32;
  localparam int REG_WIDTH     = 32;
  localparam int INST_ID_W     = 8;
  localparam int LSID_W        = 4;
  localparam int STQ_DEPTH_DEF = 8;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic [REG_WIDTH-1:0]  mem_req_data;
    logic [3:0]            mem_req_strb;
    logic [INST_ID_W-1:0]  inst_id;
    logic [LSID_W-1:0]     lsid;
  } stu_pkg_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic [REG_WIDTH-1:0]  mem_req_data;
    logic [3:0]            mem_req_strb;
    logic [INST_ID_W-1:0]  inst_id;
    logic [LSID_W-1:0]     lsid;
  } stq_entry_t;

  typedef enum logic [1:0] {
    STQ_IDLE,
    STQ_REQ,
    STQ_WAIT_ACK
  } stq_state_e;

  function automatic stq_entry_t to_entry(input stu_pkg_t p);
    stq_entry_t e;
    e.mem_req_addr = p.mem_req_addr;
    e.mem_req_data = p.mem_req_data;
    e.mem_req_strb = p.mem_req_strb;
    e.inst_id      = p.inst_id;
    e.lsid         = p.lsid;
    return e;
  endfunction

endpackage

// File: rtl/toy_stq_ctrl_ptr.sv
// Circular-queue pointer with wrap bit; load takes priority over increment.
module toy_stq_ctrl_ptr #(
  parameter int PTR_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             ld_i,
  input  logic [PTR_W-1:0] ld_val_i,
  output logic [PTR_W-1:0] ptr_o
);

  logic [PTR_W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (ld_i) begin
      ptr_d = ld_val_i;
    end else if (inc_i) begin
      ptr_d = ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/toy_stq_ctrl.sv
// Store-queue controller: buffers STU stores, commits in order, drains one write at a time.
// Optional build macro TOY_STQ_PERF_CNT_EN adds saturating perf_full_cycles / perf_drained outputs.
module toy_stq_ctrl
  import toy_stq_ctrl_pkg::*;
#(
  parameter int STQ_DEPTH = STQ_DEPTH_DEF,
  parameter int PTR_W     = $clog2(STQ_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_store_vld,
  input  stu_pkg_t              s_store_pld,
  output logic                  s_store_rdy,
  input  logic                  commit_vld,
  input  logic                  flush,
  output logic                  m_mem_req_vld,
  input  logic                  m_mem_req_rdy,
  output logic [ADDR_WIDTH-1:0] m_mem_req_addr,
  output logic [REG_WIDTH-1:0]  m_mem_req_data,
  output logic [3:0]            m_mem_req_strb,
  input  logic                  m_mem_ack_vld,
  output logic                  stq_empty,
  output logic [PTR_W-1:0]      stq_cnt
`ifdef TOY_STQ_PERF_CNT_EN
  ,
  output logic [31:0]           perf_full_cycles,
  output logic [31:0]           perf_drained
`endif
);

  localparam int IDX_W = PTR_W - 1;

  logic [PTR_W-1:0] alloc_ptr, cmt_ptr, iss_ptr, cmt_nxt, iss_nxt;
  logic             full, enq, cmt_ok, ack_ok;
  stq_state_e       state_q, state_d;
  stq_entry_t       req_q, req_d;
  stq_entry_t       mem_q [STQ_DEPTH];
  logic             unused_meta;

  assign stq_cnt     = alloc_ptr - iss_ptr;
  assign stq_empty   = (stq_cnt == '0);
  assign full        = (stq_cnt == PTR_W'(STQ_DEPTH));
  assign s_store_rdy = ~full & ~flush;
  assign enq         = s_store_vld & s_store_rdy;
  assign cmt_ok      = commit_vld & (cmt_ptr != alloc_ptr);
  assign cmt_nxt     = cmt_ptr + PTR_W'(cmt_ok);
  assign ack_ok      = (state_q == STQ_WAIT_ACK) & m_mem_ack_vld;
  assign iss_nxt     = iss_ptr + PTR_W'(1);

  // Flush rewinds the tail to the commit boundary, including a same-cycle commit.
  toy_stq_ctrl_ptr #(.PTR_W(PTR_W)) u_alloc_ptr (
    .clk(clk), .rst_n(rst_n), .inc_i(enq), .ld_i(flush), .ld_val_i(cmt_nxt), .ptr_o(alloc_ptr)
  );

  toy_stq_ctrl_ptr #(.PTR_W(PTR_W)) u_cmt_ptr (
    .clk(clk), .rst_n(rst_n), .inc_i(cmt_ok), .ld_i(1'b0), .ld_val_i('0), .ptr_o(cmt_ptr)
  );

  toy_stq_ctrl_ptr #(.PTR_W(PTR_W)) u_iss_ptr (
    .clk(clk), .rst_n(rst_n), .inc_i(ack_ok), .ld_i(1'b0), .ld_val_i('0), .ptr_o(iss_ptr)
  );

  always_ff @(posedge clk) begin
    if (enq) begin
      mem_q[alloc_ptr[IDX_W-1:0]] <= to_entry(s_store_pld);
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    case (state_q)
      STQ_IDLE: begin
        if (iss_ptr != cmt_ptr) begin
          req_d   = mem_q[iss_ptr[IDX_W-1:0]];
          state_d = STQ_REQ;
        end
      end
      STQ_REQ: begin
        if (m_mem_req_rdy) begin
          state_d = STQ_WAIT_ACK;
        end
      end
      STQ_WAIT_ACK: begin
        if (m_mem_ack_vld) begin
          // Chain straight into the next committed entry without an idle bubble.
          if (iss_nxt != cmt_ptr) begin
            req_d   = mem_q[iss_nxt[IDX_W-1:0]];
            state_d = STQ_REQ;
          end else begin
            state_d = STQ_IDLE;
          end
        end
      end
      default: state_d = STQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= STQ_IDLE;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
    end
  end

  assign m_mem_req_vld  = (state_q == STQ_REQ);
  assign m_mem_req_addr = req_q.mem_req_addr;
  assign m_mem_req_data = req_q.mem_req_data;
  assign m_mem_req_strb = req_q.mem_req_strb;
  assign unused_meta    = ^{req_q.inst_id, req_q.lsid};

`ifdef TOY_STQ_PERF_CNT_EN
  logic [31:0] perf_full_q, perf_drained_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_full_q    <= '0;
      perf_drained_q <= '0;
    end else begin
      if (full && s_store_vld && !(&perf_full_q)) begin
        perf_full_q <= perf_full_q + 32'd1;
      end
      if (ack_ok && !(&perf_drained_q)) begin
        perf_drained_q <= perf_drained_q + 32'd1;
      end
    end
  end

  assign perf_full_cycles = perf_full_q;
  assign perf_drained     = perf_drained_q;
`endif

  a_commit_has_entry: assert property (@(posedge clk) disable iff (!rst_n)
    commit_vld |-> (cmt_ptr != alloc_ptr));
  a_ack_when_waiting: assert property (@(posedge clk) disable iff (!rst_n)
    m_mem_ack_vld |-> (state_q == STQ_WAIT_ACK));

endmodule

// File: tb/tb_toy_stq_ctrl.sv
// Scoreboard bench for toy_stq_ctrl: queue-level reference model plus bus monitor.
module tb_toy_stq_ctrl;
  import toy_stq_ctrl_pkg::*;

  localparam int DEPTH = 8;
  localparam int PW    = $clog2(DEPTH) + 1;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  s_store_vld = 1'b0;
  stu_pkg_t              s_store_pld = '0;
  logic                  s_store_rdy;
  logic                  commit_vld = 1'b0;
  logic                  flush = 1'b0;
  logic                  m_mem_req_vld;
  logic                  m_mem_req_rdy = 1'b0;
  logic [ADDR_WIDTH-1:0] m_mem_req_addr;
  logic [REG_WIDTH-1:0]  m_mem_req_data;
  logic [3:0]            m_mem_req_strb;
  logic                  m_mem_ack_vld = 1'b0;
  logic                  stq_empty;
  logic [PW-1:0]         stq_cnt;

  always #5 clk = ~clk;

  toy_stq_ctrl #(.STQ_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_store_vld(s_store_vld), .s_store_pld(s_store_pld), .s_store_rdy(s_store_rdy),
    .commit_vld(commit_vld), .flush(flush),
    .m_mem_req_vld(m_mem_req_vld), .m_mem_req_rdy(m_mem_req_rdy),
    .m_mem_req_addr(m_mem_req_addr), .m_mem_req_data(m_mem_req_data),
    .m_mem_req_strb(m_mem_req_strb), .m_mem_ack_vld(m_mem_ack_vld),
    .stq_empty(stq_empty), .stq_cnt(stq_cnt)
  );

  // Reference: model_q holds stores oldest-first, the first ncmt of them committed.
  stu_pkg_t model_q[$];
  stu_pkg_t exp_q[$];
  int       ncmt = 0;
  int       n_vec = 0;
  int       n_err = 0;
  bit       outstanding = 1'b0;
  int       ack_wait = 0;
  int       rdy_pct = 100;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic stu_pkg_t rand_pld();
    stu_pkg_t p;
    p.mem_req_addr = $urandom;
    p.mem_req_data = $urandom;
    p.mem_req_strb = 4'($urandom_range(1, 15));
    p.inst_id      = 8'($urandom);
    p.lsid         = 4'($urandom);
    return p;
  endfunction

  // Monitor: every accepted bus request must be the next committed store.
  bit                    prev_stall = 1'b0;
  logic [ADDR_WIDTH-1:0] prev_addr;
  logic [REG_WIDTH-1:0]  prev_data;
  logic [3:0]            prev_strb;

  always @(posedge clk) begin
    stu_pkg_t e;
    if (rst_n) begin
      if (prev_stall) begin
        check("stall_addr", m_mem_req_addr, prev_addr);
        check("stall_data", m_mem_req_data, prev_data);
        check("stall_strb", m_mem_req_strb, prev_strb);
        check("stall_vld", m_mem_req_vld, 1'b1);
      end
      if (m_mem_req_vld && m_mem_req_rdy) begin
        if (exp_q.size() == 0) begin
          check("req_without_commit", m_mem_req_vld, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("req_addr", m_mem_req_addr, e.mem_req_addr);
          check("req_data", m_mem_req_data, e.mem_req_data);
          check("req_strb", m_mem_req_strb, e.mem_req_strb);
        end
      end
      prev_stall = m_mem_req_vld && !m_mem_req_rdy;
      prev_addr  = m_mem_req_addr;
      prev_data  = m_mem_req_data;
      prev_strb  = m_mem_req_strb;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // One clock of stimulus, memory response and model update.
  task automatic step(input bit vld, input stu_pkg_t pld, input bit cmt, input bit fl, output bit acc);
    bit cmt_ok, exp_rdy, hs, ack;
    @(negedge clk);
    check("stq_cnt", stq_cnt, model_q.size());
    check("stq_empty", stq_empty, model_q.size() == 0);
    if (outstanding) check("single_outstanding", m_mem_req_vld, 1'b0);
    cmt_ok        = cmt && (ncmt < model_q.size());
    s_store_vld   = vld;
    s_store_pld   = pld;
    commit_vld    = cmt_ok;
    flush         = fl;
    m_mem_req_rdy = ($urandom_range(0, 99) < rdy_pct);
    ack           = outstanding && (ack_wait == 0);
    m_mem_ack_vld = ack;
    #1;
    exp_rdy = (model_q.size() != DEPTH) && !fl;
    check("s_store_rdy", s_store_rdy, exp_rdy);
    hs = m_mem_req_vld && m_mem_req_rdy;
    @(posedge clk);
    if (cmt_ok) begin
      exp_q.push_back(model_q[ncmt]);
      ncmt++;
    end
    if (ack) begin
      void'(model_q.pop_front());
      ncmt--;
      outstanding = 1'b0;
    end else if (outstanding && ack_wait > 0) begin
      ack_wait--;
    end
    if (fl) begin
      while (model_q.size() > ncmt) void'(model_q.pop_back());
    end
    acc = vld && exp_rdy;
    if (acc) model_q.push_back(pld);
    if (hs) begin
      outstanding = 1'b1;
      ack_wait    = $urandom_range(0, 3);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    s_store_vld = 1'b0; commit_vld = 1'b0; flush = 1'b0;
    m_mem_req_rdy = 1'b0; m_mem_ack_vld = 1'b0;
    model_q.delete(); exp_q.delete();
    ncmt = 0; outstanding = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_cnt", stq_cnt, 0);
    check("rst_empty", stq_empty, 1);
    check("rst_req_vld", m_mem_req_vld, 0);
    check("rst_addr", m_mem_req_addr, 0);
    check("rst_data", m_mem_req_data, 0);
    check("rst_strb", m_mem_req_strb, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_rdy", s_store_rdy, 1);
  endtask

  task automatic drain_all();
    bit acc;
    rdy_pct = 100;
    for (int i = 0; i < 300 && model_q.size() != 0; i++) step(1'b0, rand_pld(), 1'b1, 1'b0, acc);
    if (model_q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL drain_timeout: %0d entries left, expected 0", model_q.size());
    end
    step(1'b0, rand_pld(), 1'b0, 1'b0, acc);
    check("drain_exp_left", exp_q.size(), 0);
  endtask

  task automatic rand_phase(input int n, input int pv, input int pc, input int pf);
    bit acc;
    for (int i = 0; i < n; i++)
      step($urandom_range(0, 99) < pv, rand_pld(), $urandom_range(0, 99) < pc,
           $urandom_range(0, 99) < pf, acc);
  endtask

  initial begin
    stu_pkg_t p;
    bit acc;
    int sent;
    do_reset();

    // Single store with the classic payload.
    p = '0;
    p.mem_req_addr = 32'h100; p.mem_req_data = 32'hDEADBEEF; p.mem_req_strb = 4'hF;
    step(1'b1, p, 1'b0, 1'b0, acc);
    step(1'b0, p, 1'b1, 1'b0, acc);
    repeat (10) step(1'b0, p, 1'b0, 1'b0, acc);
    drain_all();

    // Fill to full, ninth store held until a slot frees.
    for (int i = 0; i < DEPTH + 1; i++) step(1'b1, rand_pld(), 1'b0, 1'b0, acc);
    p = rand_pld();
    acc = 1'b0;
    for (int i = 0; i < 100 && !acc; i++) step(1'b1, p, 1'b1, 1'b0, acc);
    drain_all();

    // Enqueue 4, commit 2, flush.
    for (int i = 0; i < 4; i++) step(1'b1, rand_pld(), 1'b0, 1'b0, acc);
    for (int i = 0; i < 2; i++) step(1'b0, p, 1'b1, 1'b0, acc);
    step(1'b0, p, 1'b0, 1'b1, acc);
    drain_all();

    // Memory back-pressure: request must hold stable.
    rdy_pct = 0;
    step(1'b1, rand_pld(), 1'b0, 1'b0, acc);
    step(1'b1, rand_pld(), 1'b1, 1'b0, acc);
    step(1'b0, p, 1'b1, 1'b0, acc);
    repeat (6) step(1'b0, p, 1'b0, 1'b0, acc);
    drain_all();

    // Commit and flush together with three uncommitted stores.
    for (int i = 0; i < 3; i++) step(1'b1, rand_pld(), 1'b0, 1'b0, acc);
    step(1'b0, p, 1'b1, 1'b1, acc);
    step(1'b0, p, 1'b0, 1'b0, acc);
    drain_all();

    // Twenty back-to-back stores to wrap the pointers.
    rdy_pct = 100;
    sent = 0;
    p = rand_pld();
    for (int i = 0; i < 400 && sent < 20; i++) begin
      step(1'b1, p, 1'b1, 1'b0, acc);
      if (acc) begin sent++; p = rand_pld(); end
    end
    drain_all();

    // Randomised traffic with a reset landing mid-drain.
    rdy_pct = 70;  rand_phase(400, 60, 30, 3);
    rdy_pct = 30;  rand_phase(200, 90, 10, 1);
    do_reset();
    rdy_pct = 100; rand_phase(300, 40, 50, 5);
    rdy_pct = 50;  rand_phase(300, 70, 40, 2);
    drain_all();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

endmodule
